// File: rtl/instr_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl_if
// Bus bundle between the fetch sequencer, the instruction memory and decode.
//   imem_addr / imem_data          : word address out, combinational read data in
//   redirect_valid / redirect_pc   : one-cycle PC redirect pulse and its target
//   inst_valid / inst_ready        : handshake of the fetch queue head to decode
//   inst_data / inst_pc            : queue head instruction and its address
// master : the fetch sequencer side
// slave  : the memory / decode / branch-unit side
// -----------------------------------------------------------------------------
interface instr_fetch_ctrl_if #(
  parameter int size = 32
);
  logic [size-1:0] imem_addr;
  logic [size-1:0] imem_data;
  logic            redirect_valid;
  logic [size-1:0] redirect_pc;
  logic            inst_valid;
  logic [size-1:0] inst_data;
  logic [size-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and feeds a 2-entry queue towards decode. Handles redirects, halt-word
// detection and out-of-range faults.
// Ports:
//   clka    : clock, rising edge
//   rsta    : asynchronous active-low reset
//   run     : level, starts fetching when seen in IDLE
//   halted  : halt word reached and queue drained
//   fault   : PC left the memory range, sticky until reset
//   bus     : memory / redirect / decode handshake bundle (master side)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run; redirect only loads the pc
// FETCH  | one word per cycle into the queue while there is space
// DRAIN  | halt word seen; decode empties the queue
// HALT   | halted=1, left only by reset
// FAULT  | fault=1, queue flushed, left only by reset
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int              size      = 32,
  parameter int              MemSize   = 128,
  parameter logic [size-1:0] RESET_PC  = '0,
  parameter logic [size-1:0] HALT_WORD = '1
) (
  input  logic               clka,
  input  logic               rsta,
  input  logic               run,
  output logic               halted,
  output logic               fault,
  instr_fetch_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [size-1:0] MEM_LIMIT = size'(MemSize);

  logic [2:0]      state_q, state_d;
  logic [size-1:0] pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [size-1:0] e0_data_q, e0_data_d, e0_pc_q, e0_pc_d;
  logic [size-1:0] e1_data_q, e1_data_d, e1_pc_q, e1_pc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic pop, push, flush, space;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = valid_q && bus.inst_ready;
    // A full queue still accepts a word when its head leaves this cycle.
    space   = (cnt_q != 2'd2) || pop;

    case (state_q)
      ST_IDLE: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          pc_d  = bus.redirect_pc;
        end else if (pc_q >= MEM_LIMIT) begin
          flush   = 1'b1;
          state_d = ST_FAULT;
        end else if (bus.imem_data == HALT_WORD) begin
          state_d = ST_DRAIN;
        end else if (space) begin
          push = 1'b1;
          pc_d = pc_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) begin
          flush   = 1'b1;
          pc_d    = bus.redirect_pc;
          state_d = ST_FETCH;
        end else if (cnt_q == 2'd0) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
      end
      ST_FAULT: begin
        flush = 1'b1;
      end
      default: begin
        flush   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue update: pop shifts the tail into the head and zeroes the vacated
  // slot, so an empty queue always presents zeros on inst_data/inst_pc.
  always_comb begin
    e0_data_d = e0_data_q;
    e0_pc_d   = e0_pc_q;
    e1_data_d = e1_data_q;
    e1_pc_d   = e1_pc_q;
    cnt_d     = cnt_q;

    if (pop) begin
      e0_data_d = e1_data_q;
      e0_pc_d   = e1_pc_q;
      e1_data_d = '0;
      e1_pc_d   = '0;
      cnt_d     = cnt_q - 2'd1;
    end

    if (push) begin
      if (cnt_d == 2'd0) begin
        e0_data_d = bus.imem_data;
        e0_pc_d   = pc_q;
      end else begin
        e1_data_d = bus.imem_data;
        e1_pc_d   = pc_q;
      end
      cnt_d = cnt_d + 2'd1;
    end

    if (flush) begin
      e0_data_d = '0;
      e0_pc_d   = '0;
      e1_data_d = '0;
      e1_pc_d   = '0;
      cnt_d     = 2'd0;
    end

    valid_d  = (cnt_d != 2'd0);
    halted_d = (state_d == ST_HALT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      cnt_q     <= 2'd0;
      e0_data_q <= '0;
      e0_pc_q   <= '0;
      e1_data_q <= '0;
      e1_pc_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      e0_data_q <= e0_data_d;
      e0_pc_q   <= e0_pc_d;
      e1_data_q <= e1_data_d;
      e1_pc_q   <= e1_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_data  = e0_data_q;
  assign bus.inst_pc    = e0_pc_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule
